// File: rtl/d_axi_bridge.sv
// Single-outstanding bridge from the data cache miss/writeback port to AXI, one word per transaction.
// Optional feature macro: DBRIDGE_WSTRB_EN (sized writes with byte strobes; otherwise full-word writes).
module d_axi_bridge #(
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 2;

    // ID 0 belongs to the instruction side; reusing it would alias responses at the interconnect.
    if (DATA_ID == 4'd0) begin : g_id_check
        $error("d_axi_bridge: DATA_ID must differ from the instruction-side ID 0");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_D  = 3'd2,
        S_WR_AW = 3'd3,
        S_WR_B  = 3'd4
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [SW-1:0]   r_size;
    logic            r_arvalid;
    logic            r_rready;
    logic            r_awvalid;
    logic            r_wvalid;
    logic            r_bready;
    logic            r_aw_done;
    logic            r_w_done;

    logic [SW-1:0]   w_size_norm;
    logic            w_aw_done_n;
    logic            w_w_done_n;
    logic [3:0]      w_wstrb;
    logic [2:0]      w_awsize;

    // Size 11 is not a legal single-word transfer; treat it as a full word.
    assign w_size_norm = (data_size == 2'b11) ? 2'b10 : data_size;

    // Each write channel is done once its own handshake has happened, in any order.
    assign w_aw_done_n = r_aw_done | (r_awvalid & awready);
    assign w_w_done_n  = r_w_done  | (r_wvalid  & wready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_size    <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (data_req) begin
                        r_addr  <= data_addr;
                        r_wdata <= data_wdata;
                        r_size  <= w_size_norm;
                        if (data_wr) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= S_WR_AW;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_A;
                        end
                    end
                end
                S_RD_A: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_D;
                    end
                end
                S_RD_D: begin
                    if (rvalid) begin
                        r_rready <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_WR_AW: begin
                    if (r_awvalid && awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && wready) begin
                        r_wvalid <= 1'b0;
                    end
                    r_aw_done <= w_aw_done_n;
                    r_w_done  <= w_w_done_n;
                    if (w_aw_done_n && w_w_done_n) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (bvalid) begin
                        r_bready <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                    r_bready  <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DBRIDGE_WSTRB_EN
    // Byte lanes follow the access size and the low address bits.
    always_comb begin
        w_wstrb = 4'b1111;
        case (r_size)
            2'b00: begin
                case (r_addr[1:0])
                    2'b00:   w_wstrb = 4'b0001;
                    2'b01:   w_wstrb = 4'b0010;
                    2'b10:   w_wstrb = 4'b0100;
                    default: w_wstrb = 4'b1000;
                endcase
            end
            2'b01:   w_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_wstrb = 4'b1111;
        endcase
    end
    assign w_awsize = {1'b0, r_size};
`else
    // The cache only ever writes back whole words.
    assign w_wstrb  = 4'b1111;
    assign w_awsize = 3'b010;
`endif

    assign data_addr_ok = (r_state == S_IDLE) & data_req;
    assign data_data_ok = (r_rready & rvalid) | (r_bready & bvalid);
    assign data_rdata   = rdata;

    assign araddr  = r_addr;
    assign arsize  = {1'b0, r_size};
    assign arvalid = r_arvalid;
    assign rready  = r_rready;
    assign awaddr  = r_addr;
    assign awsize  = w_awsize;
    assign awvalid = r_awvalid;
    assign wdata   = r_wdata;
    assign wstrb   = w_wstrb;
    assign wvalid  = r_wvalid;
    assign bready  = r_bready;

endmodule

// File: tb/tb_d_axi_bridge.sv
// Bench for d_axi_bridge: directed scenarios plus randomized transactions against a transaction-level model.
module tb_d_axi_bridge;

    logic        clk;
    logic        rst;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int total;
    int bad;

    d_axi_bridge #(.DATA_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: lane mask of the bytes a sized write touches.
    function automatic logic [31:0] exp_wstrb(input logic [1:0] sz, input logic [31:0] a);
`ifdef DBRIDGE_WSTRB_EN
        int nbytes;
        int first;
        logic [3:0] m;
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        first  = (nbytes == 4) ? 0 : (int'(a[1:0]) / nbytes) * nbytes;
        m = 4'b0000;
        for (int b = 0; b < 4; b++)
            if (b >= first && b < first + nbytes) m[b] = 1'b1;
        return 32'(m);
`else
        return 32'hF + 32'(sz & 2'b00) + 32'(a & 32'h0);
`endif
    endfunction

    function automatic logic [31:0] exp_sz(input logic [1:0] sz);
        return (sz == 2'b11) ? 32'd2 : 32'(sz);
    endfunction

    function automatic logic [31:0] exp_awsize(input logic [1:0] sz);
`ifdef DBRIDGE_WSTRB_EN
        return exp_sz(sz);
`else
        return 32'd2 + 32'(sz & 2'b00);
`endif
    endfunction

    logic [31:0] a, wd, rd;
    logic [1:0]  sz;
    logic        wr;
    int          da, dw, dd, n;

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; data_req = 1'b0; data_wr = 1'b0; data_size = 2'b10;
        data_addr = '0; data_wdata = '0;
        arready = 1'b0; rdata = '0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid",  32'(wvalid),  32'd0);
        chk("rst_rready",  32'(rready),  32'd0);
        chk("rst_bready",  32'(bready),  32'd0);
        chk("rst_data_ok", 32'(data_data_ok), 32'd0);
        chk("rst_addr_ok", 32'(data_addr_ok), 32'd0);
        rst = 1'b0;

        // Directed read: arready on first arvalid, rvalid one idle cycle later
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1000_0040; data_size = 2'b10;
        #1 chk("rd_addr_ok_c0", 32'(data_addr_ok), 32'd1);
        @(negedge clk);
        data_req = 1'b0; arready = 1'b1;
        #1;
        chk("rd_arvalid_c1", 32'(arvalid), 32'd1);
        chk("rd_araddr_c1", araddr, 32'h1000_0040);
        chk("rd_arsize_c1", 32'(arsize), 32'd2);
        chk("rd_addr_ok_busy", 32'(data_addr_ok), 32'd0);
        @(negedge clk);
        arready = 1'b0;
        #1;
        chk("rd_arvalid_c2", 32'(arvalid), 32'd0);
        chk("rd_rready_c2", 32'(rready), 32'd1);
        chk("rd_data_ok_c2", 32'(data_data_ok), 32'd0);
        @(negedge clk);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_data_ok_c3", 32'(data_data_ok), 32'd1);
        chk("rd_rdata_c3", data_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        chk("rd_data_ok_c4", 32'(data_data_ok), 32'd0);
        chk("rd_rready_c4", 32'(rready), 32'd0);

        // Directed write: awready c1, wready c3
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h2000_0000;
        data_wdata = 32'h1234_5678; data_size = 2'b10;
        #1 chk("wr_addr_ok_c0", 32'(data_addr_ok), 32'd1);
        @(negedge clk);
        data_req = 1'b0; awready = 1'b1;
        #1;
        chk("wr_awvalid_c1", 32'(awvalid), 32'd1);
        chk("wr_wvalid_c1", 32'(wvalid), 32'd1);
        chk("wr_awaddr_c1", awaddr, 32'h2000_0000);
        chk("wr_wdata_c1", wdata, 32'h1234_5678);
        chk("wr_wstrb_c1", 32'(wstrb), 32'hF);
        chk("wr_awsize_c1", 32'(awsize), 32'd2);
        @(negedge clk);
        awready = 1'b0;
        #1;
        chk("wr_awvalid_c2", 32'(awvalid), 32'd0);
        chk("wr_wvalid_c2", 32'(wvalid), 32'd1);
        @(negedge clk);
        wready = 1'b1;
        #1 chk("wr_wvalid_c3", 32'(wvalid), 32'd1);
        @(negedge clk);
        wready = 1'b0;
        #1;
        chk("wr_wvalid_c4", 32'(wvalid), 32'd0);
        chk("wr_bready_c4", 32'(bready), 32'd1);
        chk("wr_data_ok_c4", 32'(data_data_ok), 32'd0);
        @(negedge clk);
        bvalid = 1'b1;
        #1 chk("wr_data_ok_bvalid", 32'(data_data_ok), 32'd1);
        @(negedge clk);
        bvalid = 1'b0;
        #1;
        chk("wr_data_ok_after", 32'(data_data_ok), 32'd0);
        chk("wr_bready_after", 32'(bready), 32'd0);

        // Byte write at the top lane of a word
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h2000_0003;
        data_wdata = 32'h0000_00AB; data_size = 2'b00;
        #1 chk("bw_addr_ok", 32'(data_addr_ok), 32'd1);
        @(negedge clk);
        data_req = 1'b0; awready = 1'b1; wready = 1'b1;
        #1;
`ifdef DBRIDGE_WSTRB_EN
        chk("bw_wstrb", 32'(wstrb), 32'h8);
        chk("bw_awsize", 32'(awsize), 32'd0);
`else
        chk("bw_wstrb", 32'(wstrb), 32'hF);
        chk("bw_awsize", 32'(awsize), 32'd2);
`endif
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        #1;
        chk("bw_bready", 32'(bready), 32'd1);
        chk("bw_data_ok", 32'(data_data_ok), 32'd1);
        @(negedge clk);
        bvalid = 1'b0;

        // data_req held high while busy, then reset in RD_A
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h3000_0000; data_size = 2'b10;
        #1 chk("busy_addr_ok_c0", 32'(data_addr_ok), 32'd1);
        @(negedge clk);
        arready = 1'b1;
        #1 chk("busy_addr_ok_rda", 32'(data_addr_ok), 32'd0);
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_0001;
        #1;
        chk("busy_addr_ok_rdd", 32'(data_addr_ok), 32'd0);
        chk("busy_data_ok", 32'(data_data_ok), 32'd1);
        @(negedge clk);
        rvalid = 1'b0;
        #1 chk("busy_addr_ok_idle", 32'(data_addr_ok), 32'd1);
        @(negedge clk);
        data_req = 1'b0; rst = 1'b1;
        #1 chk("rst_mid_arvalid_before", 32'(arvalid), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_arvalid_after", 32'(arvalid), 32'd0);
        chk("rst_mid_rready_after", 32'(rready), 32'd0);
        data_req = 1'b1;
        #1 chk("rst_mid_next_addr_ok", 32'(data_addr_ok), 32'd1);
        @(negedge clk);
        data_req = 1'b0; arready = 1'b1;
        #1 chk("rst_mid_next_arvalid", 32'(arvalid), 32'd1);
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0BAD_F00D;
        #1 chk("rst_mid_next_data_ok", 32'(data_data_ok), 32'd1);

        // Randomized transactions with random slave delays
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(0, 1));
            a  = $urandom;
            wd = $urandom;
            rd = $urandom;
            sz = 2'($urandom_range(0, 3));
            da = int'($urandom_range(0, 3));
            dw = int'($urandom_range(0, 3));
            dd = int'($urandom_range(0, 3));
            @(negedge clk);
            rvalid = 1'b0; bvalid = 1'b0; arready = 1'b0; awready = 1'b0; wready = 1'b0;
            data_req = 1'b1; data_wr = wr; data_addr = a; data_wdata = wd; data_size = sz;
            #1 chk("rnd_addr_ok", 32'(data_addr_ok), 32'd1);
            if (!wr) begin
                for (int k = 0; k <= da; k++) begin
                    @(negedge clk);
                    data_req = 1'b0; arready = (k == da);
                    #1 chk("rnd_arvalid_hold", 32'(arvalid), 32'd1);
                    if (k == da) begin
                        chk("rnd_araddr", araddr, a);
                        chk("rnd_arsize", 32'(arsize), exp_sz(sz));
                    end
                end
                for (int j = 0; j <= dd; j++) begin
                    @(negedge clk);
                    arready = 1'b0; rvalid = (j == dd); rdata = (j == dd) ? rd : $urandom;
                    #1;
                    chk("rnd_rready", 32'(rready), 32'd1);
                    chk("rnd_rd_data_ok", 32'(data_data_ok), 32'(j == dd));
                    if (j == dd) chk("rnd_rdata", data_rdata, rd);
                end
            end else begin
                n = (da > dw) ? da : dw;
                for (int k = 0; k <= n; k++) begin
                    @(negedge clk);
                    data_req = 1'b0; awready = (k == da); wready = (k == dw);
                    #1;
                    chk("rnd_awvalid", 32'(awvalid), 32'(k <= da));
                    chk("rnd_wvalid", 32'(wvalid), 32'(k <= dw));
                    if (k == da) begin
                        chk("rnd_awaddr", awaddr, a);
                        chk("rnd_awsize", 32'(awsize), exp_awsize(sz));
                    end
                    if (k == dw) begin
                        chk("rnd_wdata", wdata, wd);
                        chk("rnd_wstrb", 32'(wstrb), exp_wstrb(sz, a));
                    end
                end
                for (int j = 0; j <= dd; j++) begin
                    @(negedge clk);
                    awready = 1'b0; wready = 1'b0; bvalid = (j == dd);
                    #1;
                    chk("rnd_bready", 32'(bready), 32'd1);
                    chk("rnd_wr_data_ok", 32'(data_data_ok), 32'(j == dd));
                end
            end
        end
        @(negedge clk);
        rvalid = 1'b0; bvalid = 1'b0;
        #1 chk("end_idle_data_ok", 32'(data_data_ok), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
